// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) round-robin arbiter in front of a single-port data memory,
// with a self-clearing sequence that zeroes every word after reset or on request.
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Clr_Start,
    input  logic              i_Cpu_Req,
    input  logic              i_Cpu_We,
    input  logic [ADDR_W-1:0] i_Cpu_Addr,
    input  logic [DATA_W-1:0] i_Cpu_Wdata,
    output logic              o_Cpu_Gnt,
    output logic              o_Cpu_Valid,
    output logic [DATA_W-1:0] o_Cpu_Rdata,
    input  logic              i_Dbg_Req,
    input  logic              i_Dbg_We,
    input  logic [ADDR_W-1:0] i_Dbg_Addr,
    input  logic [DATA_W-1:0] i_Dbg_Wdata,
    output logic              o_Dbg_Gnt,
    output logic              o_Dbg_Valid,
    output logic [DATA_W-1:0] o_Dbg_Rdata,
    output logic              o_Mem_We,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [DATA_W-1:0] o_Mem_Wdata,
    input  logic [DATA_W-1:0] i_Mem_Rdata,
    output logic              o_Clr_Busy
);

    typedef enum logic {S_CLEAR, S_ARB} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last_dbg_q, last_dbg_d;
    logic              cpu_pend_q, cpu_pend_d;
    logic              dbg_pend_q, dbg_pend_d;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q    <= S_CLEAR;
            cnt_q      <= '0;
            last_dbg_q <= 1'b1;
            cpu_pend_q <= 1'b0;
            dbg_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_dbg_q <= last_dbg_d;
            cpu_pend_q <= cpu_pend_d;
            dbg_pend_q <= dbg_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_dbg_d  = last_dbg_q;
        cpu_pend_d  = 1'b0;
        dbg_pend_d  = 1'b0;
        o_Cpu_Gnt   = 1'b0;
        o_Dbg_Gnt   = 1'b0;
        o_Mem_We    = 1'b0;
        o_Mem_Addr  = '0;
        o_Mem_Wdata = '0;
        o_Clr_Busy  = 1'b0;
        case (state_q)
            S_CLEAR: begin
                o_Clr_Busy = 1'b1;
                // Reset holds the state in CLEAR; keep the memory untouched meanwhile.
                o_Mem_We   = i_Rst;
                o_Mem_Addr = cnt_q;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = S_ARB;
            end
            default: begin
                if (i_Clr_Start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else begin
                    // On contention the port that did not win last time goes first.
                    o_Cpu_Gnt = i_Cpu_Req & (~i_Dbg_Req | last_dbg_q);
                    o_Dbg_Gnt = i_Dbg_Req & (~i_Cpu_Req | ~last_dbg_q);
                    if (o_Cpu_Gnt) begin
                        o_Mem_We    = i_Cpu_We;
                        o_Mem_Addr  = i_Cpu_Addr;
                        o_Mem_Wdata = i_Cpu_Wdata;
                        cpu_pend_d  = ~i_Cpu_We;
                        last_dbg_d  = 1'b0;
                    end else if (o_Dbg_Gnt) begin
                        o_Mem_We    = i_Dbg_We;
                        o_Mem_Addr  = i_Dbg_Addr;
                        o_Mem_Wdata = i_Dbg_Wdata;
                        dbg_pend_d  = ~i_Dbg_We;
                        last_dbg_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    // Read data returns one cycle after the grant, whatever state we are in by then.
    assign o_Cpu_Valid = cpu_pend_q;
    assign o_Dbg_Valid = dbg_pend_q;
    assign o_Cpu_Rdata = cpu_pend_q ? i_Mem_Rdata : '0;
    assign o_Dbg_Rdata = dbg_pend_q ? i_Mem_Rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then randomized traffic, all checked
// against a behavioural model (remaining-clear count, last winner, reference memory).
module tb_dmem_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 32;

    logic          i_Clk = 1'b0;
    logic          i_Rst = 1'b0;
    logic          i_Clr_Start = 1'b0;
    logic          i_Cpu_Req = 1'b0, i_Cpu_We = 1'b0;
    logic [AW-1:0] i_Cpu_Addr = '0;
    logic [DW-1:0] i_Cpu_Wdata = '0;
    logic          i_Dbg_Req = 1'b0, i_Dbg_We = 1'b0;
    logic [AW-1:0] i_Dbg_Addr = '0;
    logic [DW-1:0] i_Dbg_Wdata = '0;
    logic          o_Cpu_Gnt, o_Cpu_Valid, o_Dbg_Gnt, o_Dbg_Valid;
    logic [DW-1:0] o_Cpu_Rdata, o_Dbg_Rdata;
    logic          o_Mem_We, o_Clr_Busy;
    logic [AW-1:0] o_Mem_Addr;
    logic [DW-1:0] o_Mem_Wdata;
    logic [DW-1:0] i_Mem_Rdata;

    always #5 i_Clk = ~i_Clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Clr_Start(i_Clr_Start),
        .i_Cpu_Req(i_Cpu_Req), .i_Cpu_We(i_Cpu_We), .i_Cpu_Addr(i_Cpu_Addr),
        .i_Cpu_Wdata(i_Cpu_Wdata), .o_Cpu_Gnt(o_Cpu_Gnt), .o_Cpu_Valid(o_Cpu_Valid),
        .o_Cpu_Rdata(o_Cpu_Rdata),
        .i_Dbg_Req(i_Dbg_Req), .i_Dbg_We(i_Dbg_We), .i_Dbg_Addr(i_Dbg_Addr),
        .i_Dbg_Wdata(i_Dbg_Wdata), .o_Dbg_Gnt(o_Dbg_Gnt), .o_Dbg_Valid(o_Dbg_Valid),
        .o_Dbg_Rdata(o_Dbg_Rdata),
        .o_Mem_We(o_Mem_We), .o_Mem_Addr(o_Mem_Addr), .o_Mem_Wdata(o_Mem_Wdata),
        .i_Mem_Rdata(i_Mem_Rdata), .o_Clr_Busy(o_Clr_Busy)
    );

    // Synchronous-read single-port memory driven by the DUT.
    logic [DW-1:0] dev_mem [DEPTH];
    always @(posedge i_Clk) begin
        if (o_Mem_We) dev_mem[o_Mem_Addr] <= o_Mem_Wdata;
        i_Mem_Rdata <= dev_mem[o_Mem_Addr];
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int            clr_left;
    bit            last_dbg;
    bit            pv_cpu, pv_dbg;
    logic [DW-1:0] pd_cpu, pd_dbg;
    logic [DW-1:0] ref_mem [DEPTH];
    bit            g_cpu = 1'b0, g_dbg = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        clr_left = DEPTH;
        last_dbg = 1'b1;
        pv_cpu = 1'b0;
        pv_dbg = 1'b0;
        g_cpu = 1'b0;
        g_dbg = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_cpu_gnt", o_Cpu_Gnt, 0);
        chk("rst_dbg_gnt", o_Dbg_Gnt, 0);
        chk("rst_cpu_valid", o_Cpu_Valid, 0);
        chk("rst_dbg_valid", o_Dbg_Valid, 0);
        chk("rst_cpu_rdata", o_Cpu_Rdata, 0);
        chk("rst_dbg_rdata", o_Dbg_Rdata, 0);
        chk("rst_mem_we", o_Mem_We, 0);
        chk("rst_mem_addr", o_Mem_Addr, 0);
        chk("rst_mem_wdata", o_Mem_Wdata, 0);
        chk("rst_busy", o_Clr_Busy, 1);
    endtask

    // Called at posedge+1 with inputs settled; checks this cycle, advances the model.
    task automatic cycle();
        bit            e_cg, e_dg, e_we, e_busy, n_pv_cpu, n_pv_dbg;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        e_cg = 0; e_dg = 0; e_we = 0; e_a = '0; e_d = '0;
        e_busy = (clr_left > 0);
        if (clr_left > 0) begin
            e_we = 1;
            e_a  = AW'(DEPTH - clr_left);
        end else if (!i_Clr_Start) begin
            if (i_Cpu_Req && i_Dbg_Req) begin
                e_cg = last_dbg;
                e_dg = !last_dbg;
            end else begin
                e_cg = i_Cpu_Req;
                e_dg = i_Dbg_Req;
            end
            if (e_cg) begin e_we = i_Cpu_We; e_a = i_Cpu_Addr; e_d = i_Cpu_Wdata; end
            if (e_dg) begin e_we = i_Dbg_We; e_a = i_Dbg_Addr; e_d = i_Dbg_Wdata; end
        end
        @(negedge i_Clk);
        chk("cpu_gnt", o_Cpu_Gnt, e_cg);
        chk("dbg_gnt", o_Dbg_Gnt, e_dg);
        chk("mem_we", o_Mem_We, e_we);
        chk("mem_addr", o_Mem_Addr, e_a);
        chk("mem_wdata", o_Mem_Wdata, e_d);
        chk("clr_busy", o_Clr_Busy, e_busy);
        chk("cpu_valid", o_Cpu_Valid, pv_cpu);
        chk("cpu_rdata", o_Cpu_Rdata, pv_cpu ? pd_cpu : '0);
        chk("dbg_valid", o_Dbg_Valid, pv_dbg);
        chk("dbg_rdata", o_Dbg_Rdata, pv_dbg ? pd_dbg : '0);
        chk("one_valid", o_Cpu_Valid & o_Dbg_Valid, 0);
        @(posedge i_Clk);
        n_pv_cpu = e_cg && !i_Cpu_We;
        n_pv_dbg = e_dg && !i_Dbg_We;
        if (n_pv_cpu) pd_cpu = ref_mem[i_Cpu_Addr];
        if (n_pv_dbg) pd_dbg = ref_mem[i_Dbg_Addr];
        if (e_we) ref_mem[e_a] = e_d;
        if (clr_left > 0) clr_left--;
        else if (i_Clr_Start) clr_left = DEPTH;
        if (e_cg) last_dbg = 1'b0;
        if (e_dg) last_dbg = 1'b1;
        pv_cpu = n_pv_cpu;
        pv_dbg = n_pv_dbg;
        g_cpu = e_cg;
        g_dbg = e_dg;
        #1;
    endtask

    task automatic set_cpu(input bit req, input bit we, input int a, input logic [DW-1:0] d);
        i_Cpu_Req = req; i_Cpu_We = we; i_Cpu_Addr = AW'(a); i_Cpu_Wdata = d;
    endtask

    task automatic set_dbg(input bit req, input bit we, input int a, input logic [DW-1:0] d);
        i_Dbg_Req = req; i_Dbg_We = we; i_Dbg_Addr = AW'(a); i_Dbg_Wdata = d;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            dev_mem[i] = $urandom;
            ref_mem[i] = 'x;
        end
        model_reset();
        #2 chk_reset();
        @(posedge i_Clk); #1;
        chk_reset();
        i_Rst = 1'b1;

        // Power-up clear, then one idle ARB cycle
        repeat (DEPTH + 1) cycle();

        // CPU write then read of address 3
        set_cpu(1, 1, 3, 32'hDEADBEEF); cycle();
        set_cpu(1, 0, 3, 0);            cycle();
        set_cpu(0, 0, 0, 0);            cycle();

        // Seed addresses 1/2, leaving Dbg as last winner, then contended reads
        set_cpu(1, 1, 1, 32'h1111_1111); cycle();
        set_cpu(0, 0, 0, 0);
        set_dbg(1, 1, 2, 32'h2222_2222); cycle();
        set_cpu(1, 0, 1, 0);
        set_dbg(1, 0, 2, 0);
        repeat (4) cycle();
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        cycle();

        // Soft clear with CPU read pending; earlier data must read back as zero
        set_cpu(1, 1, 7, 32'h7777_7777); cycle();
        set_cpu(0, 0, 0, 0);
        set_dbg(1, 0, 3, 0);             cycle();
        set_dbg(0, 0, 0, 0);
        set_cpu(1, 0, 7, 0);
        i_Clr_Start = 1'b1;              cycle();
        i_Clr_Start = 1'b0;
        repeat (DEPTH + 1) cycle();
        set_cpu(0, 0, 0, 0);             cycle();

        // Reset at clear counter 10, then a Dbg write held through the restarted clear
        i_Clr_Start = 1'b1; cycle();
        i_Clr_Start = 1'b0;
        repeat (10) cycle();
        i_Rst = 1'b0;
        #1 chk_reset();
        model_reset();
        @(posedge i_Clk); #1;
        chk_reset();
        i_Rst = 1'b1;
        set_dbg(1, 1, 5, 32'h12);
        repeat (DEPTH + 1) cycle();
        set_dbg(1, 0, 5, 0); cycle();
        set_dbg(0, 0, 0, 0); cycle();

        // Randomized traffic; requesters hold until granted
        for (int n = 0; n < 600; n++) begin
            if (!i_Cpu_Req || g_cpu)
                set_cpu(($urandom % 3) != 0, $urandom % 2, $urandom % DEPTH, $urandom);
            if (!i_Dbg_Req || g_dbg)
                set_dbg(($urandom % 3) != 0, $urandom % 2, $urandom % DEPTH, $urandom);
            i_Clr_Start = (($urandom % 60) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
